// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC scan scheduler.
package adc_sched_pkg;

  localparam int ADC_W  = 12;
  localparam int CH_W   = 3;
  localparam int NUM_CH = 8;
  localparam int CNT_W  = 13;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    ACCUM  = 3'd4,
    OUTPUT = 3'd5,
    ABORT  = 3'd6
  } state_e;

endpackage

// File: rtl/adc_scan_sched_if.sv
// ADC-core handshake plus averaged-sample stream of the scan scheduler.
interface adc_scan_sched_if;
  import adc_sched_pkg::*;

  logic [CH_W-1:0]  adc_chan;
  logic             adc_start;
  logic             adc_done;
  logic [ADC_W-1:0] adc_result;
  logic [ADC_W-1:0] sample_data;
  logic [CH_W-1:0]  sample_ch;
  logic             sample_valid;

  // Scheduler side: drives the ADC core and publishes samples.
  modport master (
    output adc_chan, adc_start, sample_data, sample_ch, sample_valid,
    input  adc_done, adc_result
  );

  // ADC core / consumer side.
  modport slave (
    input  adc_chan, adc_start, sample_data, sample_ch, sample_valid,
    output adc_done, adc_result
  );

endinterface

// File: rtl/rr_next_ch.sv
// Rotating-priority channel finder: first set mask bit strictly after
// 'last' (wrapping), or the first set bit from channel 0 when 'last' is invalid.
module rr_next_ch
  import adc_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   last,
  input  logic              last_valid,
  output logic [CH_W-1:0]   next,
  output logic              found
);

  logic [CH_W-1:0] base_s;
  logic [CH_W-1:0] idx_s;

  // Walk offsets 1..NUM_CH from the base; offset NUM_CH wraps back onto
  // 'last' itself so a lone set channel is reselected.
  always_comb begin
    base_s = last_valid ? last : {CH_W{1'b1}};
    next   = {CH_W{1'b0}};
    found  = 1'b0;
    idx_s  = {CH_W{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_s = base_s + CH_W'(i);
      if (!found && mask[idx_s]) begin
        next  = idx_s;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// Round-robin scan sequencer for the shared 8-channel ADC: settle after a
// mux change, average 2^AVG_LOG2 conversions per visit, abort on timeout.
module adc_scan_sched
  import adc_sched_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int SETTLE_CYC  = 100,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              err_clr,
  output logic              busy,
  output logic              timeout_err,
  adc_scan_sched_if.master  bus
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;
  localparam logic [N_W-1:0]   N_LAST       = N_W'(32'd1 << AVG_LOG2);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [CH_W-1:0]  chan_q, chan_d;
  logic             last_valid_q, last_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ADC_W-1:0] res_q, res_d;
  logic             adc_start_q, adc_start_d;
  logic [ADC_W-1:0] sample_data_q, sample_data_d;
  logic [CH_W-1:0]  sample_ch_q, sample_ch_d;
  logic             sample_valid_q, sample_valid_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;

  logic [CH_W-1:0]  next_ch_s;
  logic             found_s;
  logic             abort_set_s;
  logic [N_W-1:0]   n_inc_s;
  logic [ACC_W-1:0] acc_sum_s;

  rr_next_ch u_rr_next_ch (
    .mask       (ch_mask),
    .last       (chan_q),
    .last_valid (last_valid_q),
    .next       (next_ch_s),
    .found      (found_s)
  );

  assign n_inc_s   = n_q + N_W'(1);
  assign acc_sum_s = acc_q + ACC_W'(res_q);

  // Next-state and next-output logic; the counter is shared between the
  // settle delay and the conversion timeout since they never overlap.
  always_comb begin
    state_d        = state_q;
    chan_d         = chan_q;
    last_valid_d   = last_valid_q;
    cnt_d          = cnt_q;
    n_d            = n_q;
    acc_d          = acc_q;
    res_d          = res_q;
    sample_data_d  = sample_data_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    abort_set_s    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (enable && found_s) begin
          chan_d       = next_ch_s;
          last_valid_d = 1'b1;
          // Same mux setting as last visit: the input is already settled.
          if (last_valid_q && (next_ch_s == chan_q)) begin
            state_d = START;
          end else begin
            state_d = SETTLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = START;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      START: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the expiry cycle still counts as a result.
        if (bus.adc_done) begin
          res_d   = bus.adc_result;
          state_d = ACCUM;
        end else if (cnt_q == TIMEOUT_LAST) begin
          abort_set_s = 1'b1;
          state_d     = ABORT;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      ACCUM: begin
        acc_d = acc_sum_s;
        n_d   = n_inc_s;
        if (n_inc_s == N_LAST) begin
          sample_data_d  = ADC_W'(acc_sum_s >> AVG_LOG2);
          sample_ch_d    = chan_q;
          sample_valid_d = 1'b1;
          state_d        = OUTPUT;
        end else begin
          state_d = START;
        end
      end
      OUTPUT: begin
        acc_d   = {ACC_W{1'b0}};
        n_d     = {N_W{1'b0}};
        state_d = IDLE;
      end
      ABORT: begin
        acc_d   = {ACC_W{1'b0}};
        n_d     = {N_W{1'b0}};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    adc_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);

    // A new timeout outranks a simultaneous clear request.
    if (abort_set_s) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // State and output registers; all return to idle values on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      chan_q         <= {CH_W{1'b0}};
      last_valid_q   <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
      n_q            <= {N_W{1'b0}};
      acc_q          <= {ACC_W{1'b0}};
      res_q          <= {ADC_W{1'b0}};
      adc_start_q    <= 1'b0;
      sample_data_q  <= {ADC_W{1'b0}};
      sample_ch_q    <= {CH_W{1'b0}};
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      chan_q         <= chan_d;
      last_valid_q   <= last_valid_d;
      cnt_q          <= cnt_d;
      n_q            <= n_d;
      acc_q          <= acc_d;
      res_q          <= res_d;
      adc_start_q    <= adc_start_d;
      sample_data_q  <= sample_data_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.adc_chan     = chan_q;
  assign bus.adc_start    = adc_start_q;
  assign bus.sample_data  = sample_data_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.sample_valid = sample_valid_q;
  assign busy             = busy_q;
  assign timeout_err      = timeout_err_q;

endmodule
